cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles waiting for cache_ready before abort.
REQ-002 Parameter ERR_DATA, default 32'hDEAD_BEEF: read data returned on timeout.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 pN_req_valid  input  1  port N (N=0,1) request pending.
REQ-006 pN_req_ready  output  1  port N request accepted this cycle.
REQ-007 pN_addr  input  32  port N byte address.
REQ-008 pN_wdata  input  32  port N write data.
REQ-009 pN_rw  input  1  port N 0=read, 1=write.
REQ-010 pN_resp_valid  output  1  port N response strobe, one cycle.
REQ-011 pN_rdata  output  32  port N read data, valid with pN_resp_valid.
REQ-012 cache_req  output  1  operation request to cache controller.
REQ-013 cache_addr / cache_wdata  output  32 each  latched address / write data.
REQ-014 cache_rw  output  1  latched direction.
REQ-015 cache_rdata  input  32  cache read data, valid with cache_ready.
REQ-016 cache_ready  input  1  cache operation complete, one-cycle pulse.
REQ-017 timeout_err  output  1  sticky timeout flag.
REQ-018 pN_grant_cnt  output  16  accepted-request count for port N.

Function
REQ-019 FSM states IDLE, BUSY, RESP; arbiter shares one cache controller between two ports.
REQ-020 IDLE: if any pN_req_valid, select winner, assert winner's pN_req_ready for that one cycle, latch addr/wdata/rw/port, go BUSY; else stay IDLE.
REQ-021 Arbitration: single requester wins; both valid -> port not granted last wins (round-robin); after reset port 0 wins first tie.
REQ-022 BUSY: cache_req=1 with latched fields stable every cycle until cache_ready; cache_ready=1 -> capture cache_rdata, go RESP.
REQ-023 RESP: granted port's pN_resp_valid=1 one cycle; pN_rdata=captured data for reads, 32'h0 for writes; next state IDLE.
REQ-024 Latency: accept at cycle T, cache_req first high T+1, cache_ready at T+k -> pN_resp_valid at T+k+1; next accept no earlier than T+k+2.
REQ-025 Requesters hold valid and fields stable until req_ready; req_ready never asserted outside IDLE.
REQ-026 Timeout: 8-bit-or-wider counter cleared on BUSY entry, incremented per BUSY cycle; reaching TIMEOUT without cache_ready -> timeout_err=1 (sticky), cache_req=0, go RESP with pN_rdata=ERR_DATA.
REQ-027 cache_ready arriving the same cycle the counter reaches TIMEOUT counts as success, no error.
REQ-028 cache_ready outside BUSY ignored.
REQ-029 pN_grant_cnt increments on each accept, saturates at 16'hFFFF.
REQ-030 pN_rdata holds last value between responses; non-granted port's resp_valid stays 0.

Reset
REQ-031 rst=1 -> state IDLE, all req_ready/resp_valid/cache_req=0, cache_addr/wdata/rw=0, pN_rdata=0, timeout_err=0, grant counts=0, round-robin pointer favours port 0.
REQ-032 Reset mid-BUSY drops cache_req immediately; in-flight request discarded with no response.

Structure
REQ-033 Package cache_arb_pkg holds state encoding, TIMEOUT and ERR_DATA defaults.
REQ-034 One sub-module rr_arbiter2: two request bits plus last-grant pointer in, one-hot grant out, combinational.

Verification
REQ-035 p0 read 0x0000_0040, cache_ready after 3 BUSY cycles with rdata 0x40 -> p0_resp_valid one cycle, p0_rdata=0x40, p0_grant_cnt=1.
REQ-036 p0 and p1 valid together, continuously, 4 requests -> grants alternate p0,p1,p0,p1; each count=2.
REQ-037 p1 write 0x1234_5678 to 0x80 -> cache_rw=1, cache_wdata=0x1234_5678 held until cache_ready; p1_rdata=0.
REQ-038 cache_ready never asserted, TIMEOUT=255 -> after 255 BUSY cycles timeout_err=1, cache_req=0, resp rdata=0xDEAD_BEEF; next request still served.
REQ-039 rst pulsed 2 cycles into BUSY -> cache_req=0 asynchronously, no resp_valid, counts=0, next tie goes to port 0.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// Purpose: shared state encoding, parameter defaults and helpers for the cache arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int          TIMEOUT_DEF  = 255;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

    // Grant counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cache_arbiter_if.sv
// Purpose: bundles the two requester ports, the cache-controller side and status outputs.
// Latency: n/a (wires only).
// Backpressure: requesters hold valid/fields until req_ready; the cache answers with a ready pulse.
interface cache_arbiter_if;

    logic        p0_req_valid;
    logic        p0_req_ready;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic        p0_rw;
    logic        p0_resp_valid;
    logic [31:0] p0_rdata;
    logic [15:0] p0_grant_cnt;

    logic        p1_req_valid;
    logic        p1_req_ready;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        p1_rw;
    logic        p1_resp_valid;
    logic [31:0] p1_rdata;
    logic [15:0] p1_grant_cnt;

    logic        cache_req;
    logic [31:0] cache_addr;
    logic [31:0] cache_wdata;
    logic        cache_rw;
    logic [31:0] cache_rdata;
    logic        cache_ready;

    logic        timeout_err;

    // Arbiter side.
    modport slave (
        input  p0_req_valid, p0_addr, p0_wdata, p0_rw,
        input  p1_req_valid, p1_addr, p1_wdata, p1_rw,
        input  cache_rdata, cache_ready,
        output p0_req_ready, p0_resp_valid, p0_rdata, p0_grant_cnt,
        output p1_req_ready, p1_resp_valid, p1_rdata, p1_grant_cnt,
        output cache_req, cache_addr, cache_wdata, cache_rw,
        output timeout_err
    );

    // Requesters plus cache controller side.
    modport master (
        output p0_req_valid, p0_addr, p0_wdata, p0_rw,
        output p1_req_valid, p1_addr, p1_wdata, p1_rw,
        output cache_rdata, cache_ready,
        input  p0_req_ready, p0_resp_valid, p0_rdata, p0_grant_cnt,
        input  p1_req_ready, p1_resp_valid, p1_rdata, p1_grant_cnt,
        input  cache_req, cache_addr, cache_wdata, cache_rw,
        input  timeout_err
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Purpose: two-way round-robin pick; a tie goes to the port that was not granted last.
// Latency: combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // One-hot grant: single requester wins outright, tie flips away from the last winner.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/cache_arbiter.sv
// Purpose: shares one cache controller between two request ports, with timeout abort.
// Latency: accept T, cache_req from T+1, cache_ready at T+k -> resp_valid at T+k+1.
// Backpressure: one operation in flight; req_ready only in IDLE, next accept no earlier than T+k+2.
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int          TIMEOUT  = TIMEOUT_DEF,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic            clk,
    input  logic            rst,
    cache_arbiter_if.slave  bus
);

    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    state_t        state, state_nxt;
    logic [1:0]    gnt;
    logic          accept;
    logic          tmo_hit;
    logic          last;        // 1 = port 1 was granted last
    logic          sel;         // port owning the in-flight operation
    logic [CW-1:0] tmo_cnt;
    logic [31:0]   addr_q, wdata_q;
    logic          rw_q;
    logic [31:0]   rdata0_q, rdata1_q;
    logic [15:0]   cnt0_q, cnt1_q;
    logic          tmo_err_q;
    logic [31:0]   resp_dat;

    rr_arbiter2 u_rr (
        .req  ({bus.p1_req_valid, bus.p0_req_valid}),
        .last (last),
        .gnt  (gnt)
    );

    // Next-state and accept/timeout decode.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|gnt) begin
                    accept    = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A ready that lands on the final counted cycle still wins over the timeout.
                if (bus.cache_ready) begin
                    state_nxt = ST_RESP;
                end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
                    tmo_hit   = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset drops cache_req at once and discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    assign resp_dat = tmo_hit ? ERR_DATA : (rw_q ? 32'h0 : bus.cache_rdata);

    // Request latch, grant bookkeeping, timeout counter and per-port response data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last      <= 1'b1;
            sel       <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rw_q      <= 1'b0;
            tmo_cnt   <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            if (accept) begin
                sel     <= gnt[1];
                last    <= gnt[1];
                addr_q  <= gnt[1] ? bus.p1_addr  : bus.p0_addr;
                wdata_q <= gnt[1] ? bus.p1_wdata : bus.p0_wdata;
                rw_q    <= gnt[1] ? bus.p1_rw    : bus.p0_rw;
                tmo_cnt <= '0;
                if (gnt[1]) cnt1_q <= sat_inc16(cnt1_q);
                else        cnt0_q <= sat_inc16(cnt0_q);
            end else if (state == ST_BUSY) begin
                tmo_cnt <= tmo_cnt + CW'(1);
            end
            if (state == ST_BUSY && state_nxt == ST_RESP) begin
                if (sel) rdata1_q <= resp_dat;
                else     rdata0_q <= resp_dat;
                if (tmo_hit) tmo_err_q <= 1'b1;
            end
        end
    end

    assign bus.p0_req_ready  = accept & gnt[0];
    assign bus.p1_req_ready  = accept & gnt[1];
    assign bus.p0_resp_valid = (state == ST_RESP) && !sel;
    assign bus.p1_resp_valid = (state == ST_RESP) &&  sel;
    assign bus.p0_rdata      = rdata0_q;
    assign bus.p1_rdata      = rdata1_q;
    assign bus.p0_grant_cnt  = cnt0_q;
    assign bus.p1_grant_cnt  = cnt1_q;
    assign bus.cache_req     = (state == ST_BUSY);
    assign bus.cache_addr    = addr_q;
    assign bus.cache_wdata   = wdata_q;
    assign bus.cache_rw      = rw_q;
    assign bus.timeout_err   = tmo_err_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Purpose: directed self-checking bench for the two-port cache arbiter.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: bench plays both requesters and the cache controller.
module tb_cache_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cache_arbiter_if bus ();

    cache_arbiter #(
        .TIMEOUT  (255),
        .ERR_DATA (32'hDEAD_BEEF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        bus.p0_req_valid = 0; bus.p0_addr = 0; bus.p0_wdata = 0; bus.p0_rw = 0;
        bus.p1_req_valid = 0; bus.p1_addr = 0; bus.p1_wdata = 0; bus.p1_rw = 0;
        bus.cache_rdata  = 0; bus.cache_ready = 0;

        // Reset state
        repeat (2) tick;
        chk("rst_p0_ready", bus.p0_req_ready, 0);
        chk("rst_p1_ready", bus.p1_req_ready, 0);
        chk("rst_p0_resp", bus.p0_resp_valid, 0);
        chk("rst_p1_resp", bus.p1_resp_valid, 0);
        chk("rst_cache_req", bus.cache_req, 0);
        chk("rst_cache_addr", bus.cache_addr, 0);
        chk("rst_cache_wdata", bus.cache_wdata, 0);
        chk("rst_cache_rw", bus.cache_rw, 0);
        chk("rst_p0_rdata", bus.p0_rdata, 0);
        chk("rst_p1_rdata", bus.p1_rdata, 0);
        chk("rst_tmo", bus.timeout_err, 0);
        chk("rst_cnt0", bus.p0_grant_cnt, 0);
        chk("rst_cnt1", bus.p1_grant_cnt, 0);
        rst = 0;
        tick;

        // p0 read, ready on third BUSY cycle
        bus.p0_req_valid = 1; bus.p0_addr = 32'h40; bus.p0_rw = 0;
        #1;
        chk("rd_p0_ready", bus.p0_req_ready, 1);
        chk("rd_p1_ready", bus.p1_req_ready, 0);
        tick;
        bus.p0_req_valid = 0;
        chk("rd_busy_req", bus.cache_req, 1);
        chk("rd_busy_addr", bus.cache_addr, 32'h40);
        chk("rd_busy_rw", bus.cache_rw, 0);
        chk("rd_busy_noready", bus.p0_req_ready, 0);
        chk("rd_cnt0", bus.p0_grant_cnt, 1);
        tick;
        chk("rd_busy2_req", bus.cache_req, 1);
        tick;
        bus.cache_ready = 1; bus.cache_rdata = 32'h40;
        tick;
        bus.cache_ready = 0;
        chk("rd_resp_p0", bus.p0_resp_valid, 1);
        chk("rd_resp_p1", bus.p1_resp_valid, 0);
        chk("rd_rdata", bus.p0_rdata, 32'h40);
        chk("rd_resp_req", bus.cache_req, 0);
        tick;
        chk("rd_resp_oneshot", bus.p0_resp_valid, 0);
        chk("rd_rdata_hold", bus.p0_rdata, 32'h40);

        // Stray cache_ready in IDLE is ignored
        bus.cache_ready = 1; bus.cache_rdata = 32'h99;
        tick;
        bus.cache_ready = 0;
        chk("stray_req", bus.cache_req, 0);
        chk("stray_resp0", bus.p0_resp_valid, 0);
        tick;
        chk("stray_resp0b", bus.p0_resp_valid, 0);
        chk("stray_rdata", bus.p0_rdata, 32'h40);

        // Fresh reset, then continuous tie: p0,p1,p0,p1
        rst = 1; tick; rst = 0; tick;
        bus.p0_req_valid = 1; bus.p0_addr = 32'h100; bus.p0_rw = 0;
        bus.p1_req_valid = 1; bus.p1_addr = 32'h200; bus.p1_rw = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_p0_ready", bus.p0_req_ready, (i % 2 == 0) ? 1 : 0);
            chk("rr_p1_ready", bus.p1_req_ready, (i % 2 == 1) ? 1 : 0);
            tick;
            chk("rr_addr", bus.cache_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
            bus.cache_ready = 1; bus.cache_rdata = 32'hA0 + i;
            tick;
            bus.cache_ready = 0;
            chk("rr_resp0", bus.p0_resp_valid, (i % 2 == 0) ? 1 : 0);
            chk("rr_resp1", bus.p1_resp_valid, (i % 2 == 1) ? 1 : 0);
            chk("rr_no_ready_resp", bus.p0_req_ready, 0);
            chk("rr_rdata", (i % 2 == 0) ? bus.p0_rdata : bus.p1_rdata, 32'hA0 + i);
            tick;
        end
        bus.p0_req_valid = 0; bus.p1_req_valid = 0;
        chk("rr_cnt0", bus.p0_grant_cnt, 2);
        chk("rr_cnt1", bus.p1_grant_cnt, 2);

        // p1 write, fields held through BUSY, write returns zero data
        bus.p1_req_valid = 1; bus.p1_addr = 32'h80; bus.p1_wdata = 32'h1234_5678; bus.p1_rw = 1;
        #1;
        chk("wr_p1_ready", bus.p1_req_ready, 1);
        chk("wr_p0_ready", bus.p0_req_ready, 0);
        tick;
        bus.p1_req_valid = 0; bus.p1_wdata = 0; bus.p1_rw = 0;
        for (int j = 0; j < 2; j++) begin
            chk("wr_rw", bus.cache_rw, 1);
            chk("wr_wdata", bus.cache_wdata, 32'h1234_5678);
            chk("wr_addr", bus.cache_addr, 32'h80);
            tick;
        end
        bus.cache_ready = 1; bus.cache_rdata = 32'hFFFF_FFFF;
        chk("wr_wdata_last", bus.cache_wdata, 32'h1234_5678);
        tick;
        bus.cache_ready = 0;
        chk("wr_resp1", bus.p1_resp_valid, 1);
        chk("wr_resp0", bus.p0_resp_valid, 0);
        chk("wr_rdata", bus.p1_rdata, 0);
        chk("wr_p0_hold", bus.p0_rdata, 32'hA2);
        chk("wr_cnt1", bus.p1_grant_cnt, 3);
        tick;

        // cache_ready on the 255th BUSY cycle is a success
        bus.p0_req_valid = 1; bus.p0_addr = 32'h300; bus.p0_rw = 0;
        #1;
        chk("edge_ready", bus.p0_req_ready, 1);
        tick;
        bus.p0_req_valid = 0;
        repeat (254) tick;
        chk("edge_req", bus.cache_req, 1);
        bus.cache_ready = 1; bus.cache_rdata = 32'h77;
        tick;
        bus.cache_ready = 0;
        chk("edge_resp", bus.p0_resp_valid, 1);
        chk("edge_rdata", bus.p0_rdata, 32'h77);
        chk("edge_tmo", bus.timeout_err, 0);
        tick;

        // Timeout: no cache_ready at all
        bus.p0_req_valid = 1; bus.p0_addr = 32'h400; bus.p0_rw = 0;
        #1;
        chk("to_ready", bus.p0_req_ready, 1);
        tick;
        bus.p0_req_valid = 0;
        chk("to_tmo_before", bus.timeout_err, 0);
        n = 0;
        while (bus.cache_req === 1'b1 && n < 300) begin
            n++;
            tick;
        end
        chk("to_busy_cycles", n, 255);
        chk("to_tmo", bus.timeout_err, 1);
        chk("to_req_low", bus.cache_req, 0);
        chk("to_resp", bus.p0_resp_valid, 1);
        chk("to_rdata", bus.p0_rdata, 32'hDEAD_BEEF);
        tick;
        chk("to_sticky", bus.timeout_err, 1);
        chk("to_resp_oneshot", bus.p0_resp_valid, 0);
        bus.p1_req_valid = 1; bus.p1_addr = 32'h500; bus.p1_rw = 0;
        #1;
        chk("to_next_ready", bus.p1_req_ready, 1);
        tick;
        bus.p1_req_valid = 0;
        bus.cache_ready = 1; bus.cache_rdata = 32'h5555;
        tick;
        bus.cache_ready = 0;
        chk("to_next_resp", bus.p1_resp_valid, 1);
        chk("to_next_rdata", bus.p1_rdata, 32'h5555);
        chk("to_next_sticky", bus.timeout_err, 1);
        tick;

        // Reset two cycles into BUSY after a p0 grant
        bus.p0_req_valid = 1; bus.p0_addr = 32'h600; bus.p0_rw = 0;
        #1;
        chk("rb_ready", bus.p0_req_ready, 1);
        tick;
        bus.p0_req_valid = 0;
        tick;
        chk("rb_req_high", bus.cache_req, 1);
        #2 rst = 1;
        #1;
        chk("rb_req_async", bus.cache_req, 0);
        tick;
        chk("rb_cnt0", bus.p0_grant_cnt, 0);
        chk("rb_cnt1", bus.p1_grant_cnt, 0);
        chk("rb_tmo", bus.timeout_err, 0);
        chk("rb_rdata0", bus.p0_rdata, 0);
        chk("rb_rdata1", bus.p1_rdata, 0);
        rst = 0;
        tick;
        chk("rb_no_resp0", bus.p0_resp_valid, 0);
        chk("rb_no_resp1", bus.p1_resp_valid, 0);
        chk("rb_idle_req", bus.cache_req, 0);
        bus.p0_req_valid = 1; bus.p0_addr = 32'h700;
        bus.p1_req_valid = 1; bus.p1_addr = 32'h800;
        #1;
        chk("rb_tie_p0", bus.p0_req_ready, 1);
        chk("rb_tie_p1", bus.p1_req_ready, 0);
        tick;
        bus.p0_req_valid = 0; bus.p1_req_valid = 0;
        chk("rb_tie_addr", bus.cache_addr, 32'h700);
        bus.cache_ready = 1; bus.cache_rdata = 32'h7;
        tick;
        bus.cache_ready = 0;
        chk("rb_tie_resp", bus.p0_resp_valid, 1);
        chk("rb_tie_rdata", bus.p0_rdata, 32'h7);
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
